fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO; successor to the fixed 4x4 synchronous FIFO.
- Arbitrary depth, not limited to powers of two.
- Exact occupancy count.
- Programmable almost-full and almost-empty thresholds.
- Overflow and underflow error pulses.
- Selectable read mode: registered (legacy) or first-word-fall-through.
- Used as the generic single-clock buffer between producer and consumer blocks.

Parameters:
DATA_WIDTH, 8, width of WR/RD words
DEPTH, 16, number of entries (>=2, any integer)
AF_LEVEL, 12, ALMOST_FULL asserts when COUNT >= AF_LEVEL
AE_LEVEL, 4, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL
FWFT, 0, 0 = registered read (data one cycle after accepted read); 1 = first-word-fall-through
(derived) PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
w_en  input  1  write request
WR  input  DATA_WIDTH  write data
r_en  input  1  read request (FWFT=1: acknowledge/pop of head word)
RD  output  DATA_WIDTH  read data
RD_VALID  output  1  FWFT=0: pulse, RD holds newly read word; FWFT=1: RD valid (= !EMPTY)
FULL  output  1  COUNT == DEPTH
EMPTY  output  1  COUNT == 0
ALMOST_FULL  output  1  COUNT >= AF_LEVEL
ALMOST_EMPTY  output  1  COUNT <= AE_LEVEL
COUNT  output  CNT_W  current occupancy
OVERFLOW  output  1  one-cycle pulse: write requested while FULL
UNDERFLOW  output  1  one-cycle pulse: read requested while EMPTY

Behaviour:
- Reset (rst=1 at posedge): w_ptr=r_ptr=0, COUNT=0, RD=0, RD_VALID=0, OVERFLOW=UNDERFLOW=0; hence EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0). Memory contents are not reset.
- Reset mid-operation discards all stored data; the first write after reset lands at entry 0.
- Accept rules:
  - wr_acc = w_en & !FULL.
  - rd_acc = r_en & !EMPTY.
  - No write-through when FULL, even with a simultaneous read.
  - No read-through when EMPTY, even with a simultaneous write.
- Pointers: increment by 1 on acceptance; wrap DEPTH-1 -> 0 explicitly, not by binary overflow.
- COUNT update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
  - FULL/EMPTY/ALMOST_* are decoded combinationally from the registered COUNT.
- Memory write: mem[w_ptr] <= WR on wr_acc.
- FWFT=0 (read mode):
  - On rd_acc: RD <= mem[r_ptr] and RD_VALID <= 1.
  - Otherwise RD holds its value and RD_VALID <= 0.
  - Read latency is 1 cycle.
- FWFT=1 (read mode):
  - RD = mem[r_ptr] combinationally; RD_VALID = !EMPTY.
  - A word written into an empty FIFO appears on RD in the cycle after the write.
  - rd_acc advances to the next word.
- Error pulses: OVERFLOW <= w_en & FULL and UNDERFLOW <= r_en & EMPTY, both registered, high for exactly one cycle per offending request. The offending request has no effect on state.
- Simultaneous read+write at COUNT == 1, or at 0 < COUNT < DEPTH: both accepted; COUNT unchanged.
- Elaboration checks (error if violated): DEPTH >= 2; AF_LEVEL <= DEPTH; AE_LEVEL < DEPTH.

Decomposition:
- Shared package/header fifo_defs: FWFT mode constants (FIFO_MODE_REG=0, FIFO_MODE_FWFT=1) and a clog2 helper function for Verilog-2001 builds.
- One sub-module, fifo_ptr_wrap: parametrised pointer register.
  - Parameters: PTR_W, DEPTH.
  - Ports: clk, rst, inc, ptr.
  - Sync reset to 0; wraps at DEPTH-1.
  - Instantiated twice, for the write and read pointers.
- Use the existing d_ff_sync_en for the RD register in FWFT=0 mode.

Test Plan:
1. DEPTH=16, FWFT=0: reset, write 0x01..0x10 on consecutive cycles -> FULL=1 after the 16th write, COUNT=16, ALMOST_FULL from COUNT=12. Read 16 times -> RD=0x01..0x10 each one cycle after r_en with RD_VALID pulses, then EMPTY=1.
2. Write while FULL (WR=0xAA) -> OVERFLOW pulses one cycle, COUNT stays 16, 0xAA is never read. Read while EMPTY -> UNDERFLOW pulse, RD unchanged.
3. DEPTH=5 (non-power-of-2): 3 writes/3 reads repeated 4 times -> pointers wrap 4 -> 0, data order preserved, COUNT never exceeds 5.
4. FWFT=1: write 0x3C into an empty FIFO -> next cycle RD=0x3C with RD_VALID=1 and no r_en. Pulse r_en -> EMPTY=1, RD_VALID=0.
5. COUNT=1, w_en=r_en=1 for 10 cycles -> COUNT stays 1, each read returns the word written the previous cycle. COUNT=16 with both set -> read only, COUNT becomes 15, OVERFLOW pulses.
6. Fill to COUNT=7, assert rst for one cycle -> COUNT=0, EMPTY=1, RD=0. Next write 0x55 then read -> RD=0x55.

Source files
------------

// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: read-mode
// constants and a ceil-log2 helper for builds without $clog2.
package fifo_sync_param_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2_f(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                res = res + 1;
                v   = v >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/d_ff_sync_en.sv
// Generic register with synchronous active-high reset and load enable.
module d_ff_sync_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Load on enable, clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end else begin
            q_q <= q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fifo_ptr_wrap.sv
// Pointer register that counts 0..DEPTH-1 and wraps explicitly, so
// non-power-of-two depths never alias into unused entries.
module fifo_ptr_wrap #(
    parameter int PTR_W = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: hold, advance, or wrap at the last entry
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with exact occupancy, programmable
// almost-flags, error pulses and selectable registered/FWFT read.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] WR,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [CNT_W-1:0]      COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    if (DEPTH < 2) begin : g_chk_depth
        $error("fifo_sync_param: DEPTH must be >= 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_chk_af
        $error("fifo_sync_param: AF_LEVEL must be <= DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_chk_ae
        $error("fifo_sync_param: AE_LEVEL must be < DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      w_ptr_s;
    logic [PTR_W-1:0]      r_ptr_s;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  ovf_q;
    logic                  unf_q;

    // Flags come straight from the registered count; a full FIFO never
    // writes-through and an empty one never reads-through.
    assign full_s   = (count_q == CNT_W'(DEPTH));
    assign empty_s  = (count_q == '0);
    assign wr_acc_s = w_en & ~full_s;
    assign rd_acc_s = r_en & ~empty_s;

    fifo_ptr_wrap #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_w_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc_s),
        .ptr (w_ptr_s)
    );

    fifo_ptr_wrap #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_r_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc_s),
        .ptr (r_ptr_s)
    );

    // Occupancy next-state from the accepted write/read pair
    always_comb begin
        count_d = count_q;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Count and error-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= w_en & full_s;
            unf_q   <= r_en & empty_s;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[w_ptr_s] <= WR;
        end
    end

    if (FWFT == FIFO_MODE_REG) begin : g_rd_reg
        logic rd_valid_q;

        d_ff_sync_en #(.W(DATA_WIDTH)) u_rd_reg (
            .clk (clk),
            .rst (rst),
            .en  (rd_acc_s),
            .d   (mem[r_ptr_s]),
            .q   (RD)
        );

        // One-cycle valid pulse alongside each newly loaded word
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc_s;
            end
        end

        assign RD_VALID = rd_valid_q;
    end else begin : g_rd_fwft
        assign RD       = mem[r_ptr_s];
        assign RD_VALID = ~empty_s;
    end

    assign FULL         = full_s;
    assign EMPTY        = empty_s;
    assign ALMOST_FULL  = (count_q >= CNT_W'(AF_LEVEL));
    assign ALMOST_EMPTY = (count_q <= CNT_W'(AE_LEVEL));
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule
